ps2_device_tx: RTL and testbench

- Device-side PS/2 transmitter: the mouse end of the CLK_MOUSE/DATA_MOUSE link that the system's mouse driver receives on.
- Takes bytes over a valid/ready interface, buffers them in a small FIFO, and serialises each one as an 11-bit PS/2 frame.
- Generates the PS/2 clock itself and honours host inhibit.
- Used as a synthesizable mouse model in system benches and as a loopback source on hardware.

---
 rtl/ps2_device_tx.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_ps2_device_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_tx.sv
// ps2_device_tx -- device (mouse) side PS/2 transmitter.
//
// Bytes enter through a valid/ready handshake and wait in a small FIFO. Each
// byte is sent as an 11-bit frame (start 0, D0..D7 LSB first, odd parity,
// stop 1). This block generates the PS/2 clock itself, backs off when the
// host inhibits, and keeps a released-lines gap before every frame.
//
// Ports:
//   CLK         system clock, all logic on the rising edge
//   RESET       asynchronous active-low reset
//   TX_DATA     byte to send
//   TX_VALID    TX_DATA valid; accepted when TX_VALID & TX_READY
//   TX_READY    FIFO not full
//   CLK_MOUSE   open-drain PS/2 clock (drives 0 or Z)
//   DATA_MOUSE  open-drain PS/2 data (drives 0 or Z)
//   BUSY        frame in progress or FIFO non-empty
//   TX_DONE     one-cycle pulse when a frame completes
//   TX_ABORT    one-cycle pulse when the host inhibits a frame mid-transfer
//   RX_DATA, RX_VALID, RX_PERR  host-to-device byte (only with PS2_DEV_RX_EN)
//
// Build option: define PS2_DEV_RX_EN to add reception of host
// request-to-send commands. Without it a request-to-send is only an inhibit.
module ps2_device_tx #(
  parameter int unsigned CLK_FREQ_HZ     = 32'd100000000,
  parameter int unsigned PS2_CLK_HZ      = 32'd12500,
  parameter int unsigned IDLE_GAP_CYCLES = 32'd5000,
  parameter int unsigned FIFO_DEPTH      = 32'd4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  inout  wire        CLK_MOUSE,
  inout  wire        DATA_MOUSE,
  output logic       BUSY,
  output logic       TX_DONE,
  output logic       TX_ABORT
`ifdef PS2_DEV_RX_EN
  ,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_PERR
`endif
);

  localparam int unsigned HALF = CLK_FREQ_HZ / (32'd2 * PS2_CLK_HZ);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(32'd1);
  localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(32'd0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GAP      = 3'd1,
    S_BIT_HIGH = 3'd2,
    S_BIT_LOW  = 3'd3,
    S_DONE     = 3'd4,
    S_RX_LOW   = 3'd5,
    S_RX_HIGH  = 3'd6
  } state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push_s, pop_s;
  logic [7:0]    head_s;

  logic [1:0]    clk_sync_q, dat_sync_q, drv_dly_q;
  logic          host_low_s, host_low_prev_q, inhibit_s, lines_high_s;

  state_e        state_q;
  logic [31:0]   cnt_q;
  logic [3:0]    idx_q;
  logic [9:0]    frame_q;    // bits 1..10 of the frame still to be sent
  logic          clk_drv_q, dat_drv_q, tx_done_q, tx_abort_q;

  assign CLK_MOUSE  = clk_drv_q ? 1'b0 : 1'bz;
  assign DATA_MOUSE = dat_drv_q ? 1'b0 : 1'bz;
  assign TX_READY   = (count_q != FULL_CNT);
  assign BUSY       = (state_q != S_IDLE) | (count_q != CNT_ZERO);
  assign TX_DONE    = tx_done_q;
  assign TX_ABORT   = tx_abort_q;
  assign head_s     = mem_q[rd_ptr_q];

  // The synchronised clock lags our own drive by two cycles, so our drive
  // enable is delayed to match; only a low we are not causing is the host.
  assign host_low_s   = ~clk_sync_q[1] & ~drv_dly_q[1];
  assign inhibit_s    = host_low_s & host_low_prev_q;
  assign lines_high_s = clk_sync_q[1] & dat_sync_q[1];

`ifdef PS2_DEV_RX_EN
  localparam int unsigned RTS_CYCLES = CLK_FREQ_HZ / 32'd10000;
  logic [31:0] rts_cnt_q;
  logic        rts_s;
  logic [8:0]  rx_shift_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q, rx_perr_q;

  // Request-to-send: clock was held low long enough and is now released
  // with DATA already pulled low by the host.
  assign rts_s    = ~host_low_s & clk_sync_q[1] & ~dat_sync_q[1] & (rts_cnt_q >= RTS_CYCLES);
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign RX_PERR  = rx_perr_q;

  // Measure how long the host has been holding the clock low.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rts_cnt_q <= 32'd0;
    end else if (host_low_s) begin
      if (rts_cnt_q != 32'hFFFF_FFFF) begin
        rts_cnt_q <= rts_cnt_q + 32'd1;
      end
    end else begin
      rts_cnt_q <= 32'd0;
    end
  end
`endif

  // FIFO push/pop decode and occupancy next-state.
  always_comb begin
    push_s  = TX_VALID & TX_READY;
    pop_s   = (state_q == S_DONE);
    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_s && pop_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= CNT_ZERO;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // FIFO storage (no reset needed, occupancy guards reads).
  always_ff @(posedge CLK) begin
    if (push_s) mem_q[wr_ptr_q] <= TX_DATA;
  end

  // Line synchronisers and the delayed copy of our clock drive.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clk_sync_q      <= 2'b11;
      dat_sync_q      <= 2'b11;
      drv_dly_q       <= 2'b00;
      host_low_prev_q <= 1'b0;
    end else begin
      clk_sync_q      <= {clk_sync_q[0], CLK_MOUSE};
      dat_sync_q      <= {dat_sync_q[0], DATA_MOUSE};
      drv_dly_q       <= {drv_dly_q[0], clk_drv_q};
      host_low_prev_q <= host_low_s;
    end
  end

  // Frame sequencer with registered line drives and status pulses.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= 32'd0;
      idx_q      <= 4'd0;
      frame_q    <= 10'd0;
      clk_drv_q  <= 1'b0;
      dat_drv_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_abort_q <= 1'b0;
`ifdef PS2_DEV_RX_EN
      rx_shift_q <= 9'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      tx_done_q  <= 1'b0;
      tx_abort_q <= 1'b0;
`ifdef PS2_DEV_RX_EN
      rx_valid_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
`ifdef PS2_DEV_RX_EN
          if (rts_s) begin
            state_q <= S_RX_LOW; clk_drv_q <= 1'b1; cnt_q <= HALF - 32'd1; idx_q <= 4'd0;
          end else
`endif
          if (count_q != CNT_ZERO) begin
            state_q <= S_GAP;
            cnt_q   <= IDLE_GAP_CYCLES;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_GAP: begin
`ifdef PS2_DEV_RX_EN
          if (rts_s) begin
            state_q <= S_RX_LOW; clk_drv_q <= 1'b1; cnt_q <= HALF - 32'd1; idx_q <= 4'd0;
          end else
`endif
          if (!lines_high_s) begin
            cnt_q <= IDLE_GAP_CYCLES;
          end else if (cnt_q == 32'd0) begin
            // Start bit goes out now; the rest is queued in frame_q.
            state_q   <= S_BIT_HIGH;
            idx_q     <= 4'd0;
            cnt_q     <= HALF - 32'd1;
            frame_q   <= {1'b1, ~^head_s, head_s};
            dat_drv_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_BIT_HIGH: begin
          // A host inhibit during the stop bit is ignored.
          if (inhibit_s && (idx_q <= 4'd9)) begin
            state_q    <= S_GAP;
            cnt_q      <= IDLE_GAP_CYCLES;
            dat_drv_q  <= 1'b0;
            clk_drv_q  <= 1'b0;
            tx_abort_q <= 1'b1;
          end else if (cnt_q == 32'd0) begin
            state_q   <= S_BIT_LOW;
            clk_drv_q <= 1'b1;
            cnt_q     <= HALF - 32'd1;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_BIT_LOW: begin
          if (cnt_q != 32'd0) begin
            cnt_q <= cnt_q - 32'd1;
          end else if (idx_q == 4'd10) begin
            clk_drv_q <= 1'b0;
            dat_drv_q <= 1'b0;
            tx_done_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            clk_drv_q <= 1'b0;
            dat_drv_q <= ~frame_q[0];
            frame_q   <= {1'b1, frame_q[9:1]};
            idx_q     <= idx_q + 4'd1;
            cnt_q     <= HALF - 32'd1;
            state_q   <= S_BIT_HIGH;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
`ifdef PS2_DEV_RX_EN
        S_RX_LOW: begin
          if (cnt_q == 32'd0) begin
            clk_drv_q <= 1'b0;
            cnt_q     <= HALF - 32'd1;
            state_q   <= S_RX_HIGH;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_RX_HIGH: begin
          // Sample just after each rising edge: D0..D7 then parity.
          if ((cnt_q == HALF - 32'd1) && (idx_q <= 4'd8)) begin
            rx_shift_q <= {dat_sync_q[1], rx_shift_q[8:1]};
          end
          // Ack: pull DATA low after the stop bit, through the 11th clock.
          if ((idx_q == 4'd9) && (cnt_q == HALF / 32'd2)) begin
            dat_drv_q <= 1'b1;
          end
          if (cnt_q != 32'd0) begin
            cnt_q <= cnt_q - 32'd1;
          end else if (idx_q == 4'd10) begin
            dat_drv_q  <= 1'b0;
            rx_valid_q <= 1'b1;
            rx_data_q  <= rx_shift_q[7:0];
            rx_perr_q  <= ~^rx_shift_q;
            state_q    <= S_IDLE;
          end else begin
            clk_drv_q <= 1'b1;
            idx_q     <= idx_q + 4'd1;
            cnt_q     <= HALF - 32'd1;
            state_q   <= S_RX_LOW;
          end
        end
`endif
        default: begin
          state_q   <= S_IDLE;
          clk_drv_q <= 1'b0;
          dat_drv_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed testbench for ps2_device_tx, built with a fast PS/2 clock
// (HALF = 10 system cycles, 20-cycle idle gap) so whole frames stay short.
module tb_ps2_device_tx;

  localparam int unsigned CLK_HZ = 200;
  localparam int unsigned PS2_HZ = 10;
  localparam int unsigned GAP    = 20;
  localparam int unsigned HALF   = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_abort;
  logic       host_clk_low = 1'b0;
  wire        ps2_clk, ps2_data;

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;

  ps2_device_tx #(
    .CLK_FREQ_HZ(CLK_HZ), .PS2_CLK_HZ(PS2_HZ),
    .IDLE_GAP_CYCLES(GAP), .FIFO_DEPTH(4)
  ) dut (
    .CLK(clk), .RESET(rst_n), .TX_DATA(tx_data), .TX_VALID(tx_valid),
    .TX_READY(tx_ready), .CLK_MOUSE(ps2_clk), .DATA_MOUSE(ps2_data),
    .BUSY(busy), .TX_DONE(tx_done), .TX_ABORT(tx_abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Line monitor: data at clock falling edges, low-pulse widths,
  // released time following each TX_DONE, pulse counts.
  logic bits[$];
  int   lows[$];
  int   gaps[$];
  int   done_cnt = 0, abort_cnt = 0, low_len = 0, rel_run = 0;
  logic prev_c = 1'b1, after_done = 1'b0;

  always @(negedge clk) begin
    if (prev_c && !ps2_clk) bits.push_back(ps2_data);
    if (!ps2_clk) low_len <= low_len + 1;
    else if (!prev_c) begin lows.push_back(low_len); low_len <= 0; end
    if (ps2_clk && ps2_data) rel_run <= rel_run + 1;
    else begin
      if (after_done) begin gaps.push_back(rel_run); after_done <= 1'b0; end
      rel_run <= 0;
    end
    if (tx_done) begin done_cnt <= done_cnt + 1; after_done <= 1'b1; end
    if (tx_abort) abort_cnt <= abort_cnt + 1;
    prev_c <= ps2_clk;
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear_mon();
    bits.delete(); lows.delete(); gaps.delete();
  endtask

  task automatic push(input logic [7:0] b);
    int t = 0;
    tx_data = b; tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && t < 2000) begin step(); t++; end
    if (t >= 2000) begin checks++; failures++; $display("FAIL push_timeout byte=%h", b); end
    step();
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int t = 0;
    while (done_cnt < target && t < budget) begin step(); t++; end
    checks++;
    if (done_cnt < target) begin failures++; $display("FAIL %s_timeout done=%0d need=%0d", name, done_cnt, target); end
  endtask

  task automatic wait_bits(input int n, input int budget);
    int t = 0;
    while (bits.size() < n && t < budget) begin step(); t++; end
    checks++;
    if (bits.size() < n) begin failures++; $display("FAIL wait_bits_timeout got=%0d need=%0d", bits.size(), n); end
  endtask

  task automatic wait_clk(input logic v, input int budget);
    int t = 0;
    while (ps2_clk !== v && t < budget) begin step(); t++; end
    checks++;
    if (ps2_clk !== v) begin failures++; $display("FAIL wait_clk_timeout got=%b need=%b", ps2_clk, v); end
  endtask

  function automatic logic [10:0] frame_at(input int f);
    logic [10:0] v;
    for (int i = 0; i < 11; i++) v[i] = bits[f*11 + i];
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({tx_done, tx_abort} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {tx_done, tx_abort}); end
    checks++; if ({ps2_clk, ps2_data} !== 2'b11) begin failures++; $display("FAIL reset_lines got=%b exp=11", {ps2_clk, ps2_data}); end
  endtask

  task automatic test_single();
    int t = 0;
    int bad = 0;
    int d0 = done_cnt;
    clear_mon();
    push(8'hF4);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    while (tx_done !== 1'b1 && t < 1000) begin step(); t++; end
    checks++; if (tx_done !== 1'b1) begin failures++; $display("FAIL single_done_timeout got=%b exp=1", tx_done); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_at_done got=%b exp=1", busy); end
    step();
    checks++; if ({tx_done, busy} !== 2'b00) begin failures++; $display("FAIL single_after_done got=%b exp=00", {tx_done, busy}); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", done_cnt - d0); end
    checks++;
    if (bits.size() != 11) begin failures++; $display("FAIL single_bitcount got=%0d exp=11", bits.size()); end
    else if (frame_at(0) !== 11'b10_1111_0100_0) begin failures++; $display("FAIL single_frame got=%b exp=%b", frame_at(0), 11'b10_1111_0100_0); end
    foreach (lows[i]) if (lows[i] != HALF) bad++;
    checks++; if (lows.size() != 11 || bad != 0) begin failures++; $display("FAIL single_low_width pulses=%0d bad=%0d exp=11/0", lows.size(), bad); end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    clear_mon();
    push(8'h00);
    push(8'hFA);
    wait_done(d0 + 2, 2000, "b2b");
    repeat (5) step();
    checks++; if (done_cnt - d0 != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - d0); end
    checks++;
    if (bits.size() != 22) begin failures++; $display("FAIL b2b_bitcount got=%0d exp=22", bits.size()); end
    else if (frame_at(0) !== 11'b11_0000_0000_0 || frame_at(1) !== 11'b11_1111_1010_0) begin
      failures++; $display("FAIL b2b_frames got=%b,%b exp=%b,%b", frame_at(0), frame_at(1), 11'b11_0000_0000_0, 11'b11_1111_1010_0);
    end
    checks++;
    if (gaps.size() < 1 || gaps[0] < GAP) begin failures++; $display("FAIL b2b_gap n=%0d first=%0d need>=%0d", gaps.size(), (gaps.size() > 0) ? gaps[0] : -1, GAP); end
  endtask

  task automatic test_fifo_full();
    logic [10:0] exp_f [5] = '{11'b10_0000_0001_0, 11'b10_0000_0010_0, 11'b11_0000_0011_0,
                               11'b10_0000_0100_0, 11'b11_0000_0101_0};
    int t = 0;
    int bad = 0;
    logic seen_done = 1'b0;
    int d0 = done_cnt;
    clear_mon();
    for (int i = 1; i <= 4; i++) push(8'(i));
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", tx_ready); end
    tx_data = 8'h05; tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && t < 2000) begin
      step(); t++;
      if (tx_done === 1'b1) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b1 || tx_ready !== 1'b1) begin failures++; $display("FAIL full_held got_done=%b ready=%b exp=1,1", seen_done, tx_ready); end
    step();
    tx_valid = 1'b0;
    wait_done(d0 + 5, 3000, "full");
    checks++;
    if (bits.size() != 55) begin failures++; $display("FAIL full_bitcount got=%0d exp=55", bits.size()); end
    else begin
      for (int f = 0; f < 5; f++) if (frame_at(f) !== exp_f[f]) bad++;
      if (bad != 0) begin failures++; $display("FAIL full_frames bad=%0d exp=0", bad); end
    end
  endtask

  task automatic test_abort();
    int t = 0;
    int d0 = done_cnt;
    int a0 = abort_cnt;
    clear_mon();
    push(8'hAA);
    wait_bits(4, 1000);
    wait_clk(1'b1, 100);
    step(); step();
    host_clk_low = 1'b1;
    while (abort_cnt == a0 && t < 20) begin step(); t++; end
    checks++; if (abort_cnt - a0 != 1) begin failures++; $display("FAIL abort_pulse got=%0d exp=1", abort_cnt - a0); end
    repeat (3) step();
    checks++; if (ps2_data !== 1'b1) begin failures++; $display("FAIL abort_data_released got=%b exp=1", ps2_data); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy got=%b exp=1", busy); end
    repeat (30) step();
    host_clk_low = 1'b0;
    step();
    checks++; if (ps2_clk !== 1'b1) begin failures++; $display("FAIL abort_clk_released got=%b exp=1", ps2_clk); end
    clear_mon();
    wait_done(d0 + 1, 1000, "abort_resend");
    repeat (100) step();
    checks++; if (done_cnt - d0 != 1 || abort_cnt - a0 != 1) begin failures++; $display("FAIL abort_counts done=%0d abort=%0d exp=1,1", done_cnt - d0, abort_cnt - a0); end
    checks++;
    if (bits.size() != 11) begin failures++; $display("FAIL abort_bitcount got=%0d exp=11", bits.size()); end
    else if (frame_at(0) !== 11'b11_1010_1010_0) begin failures++; $display("FAIL abort_frame got=%b exp=%b", frame_at(0), 11'b11_1010_1010_0); end
  endtask

  task automatic test_stop_inhibit();
    int d0 = done_cnt;
    int a0 = abort_cnt;
    clear_mon();
    push(8'h55);
    wait_bits(10, 1000);
    wait_clk(1'b1, 100);
    step(); step();
    host_clk_low = 1'b1;
    repeat (4) step();
    host_clk_low = 1'b0;
    wait_done(d0 + 1, 200, "stop");
    step(); step();
    checks++; if (abort_cnt != a0) begin failures++; $display("FAIL stop_no_abort got=%0d exp=0", abort_cnt - a0); end
    checks++; if ({busy, tx_ready} !== 2'b01) begin failures++; $display("FAIL stop_popped busy_ready=%b exp=01", {busy, tx_ready}); end
    repeat (300) step();
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL stop_no_resend got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_reset_midframe();
    int d0;
    clear_mon();
    push(8'h33);
    push(8'h44);
    wait_bits(4, 1000);
    checks++; if ({ps2_clk, ps2_data} !== 2'b00) begin failures++; $display("FAIL midrst_driving got=%b exp=00", {ps2_clk, ps2_data}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({ps2_clk, ps2_data} !== 2'b11) begin failures++; $display("FAIL midrst_lines got=%b exp=11", {ps2_clk, ps2_data}); end
    checks++; if ({tx_ready, busy} !== 2'b10) begin failures++; $display("FAIL midrst_status ready_busy=%b exp=10", {tx_ready, busy}); end
    repeat (3) step();
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (600) step();
    checks++; if (done_cnt != d0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_empty done=%0d busy=%b exp=0,0", done_cnt - d0, busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_abort();
    test_stop_inhibit();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
